somador_serial: RTL and testbench

//  Bit-serial unsigned adder, the counterpart to the ALU's ripple subtractor: returns a+b (carry in MSB).

---
 rtl/somador_serial.sv | 104 ++++++++++
 tb/tb_somador_serial.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/somador_serial.sv
// Bit-serial unsigned adder: one full-adder cell plus a carry flop, LSB first, start/done handshake.
// Define SOMADOR_SERIAL_OVF_EN to add the registered signed-overflow output ovf.
module somador_serial #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH:0]   s
`ifdef SOMADOR_SERIAL_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] a_sh, b_sh;
  logic             carry;
  logic             accept;
  logic             last;
  logic             sum_bit;
  logic             carry_nxt;

  // A start is only honoured outside RUN; in DONE it chains straight into the next operation.
  assign accept    = start && (state != RUN);
  assign last      = (state == RUN) && (count == LAST_BIT);
  assign sum_bit   = a_sh[0] ^ b_sh[0] ^ carry;
  assign carry_nxt = (a_sh[0] & b_sh[0]) | (a_sh[0] & carry) | (b_sh[0] & carry);

  // NOTE: asynchronous reset in the sensitivity list, and <= for every sequential
  // assignment so all flops update together from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last)  state_nxt = DONE;
      DONE:    state_nxt = start ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: defaults written first so no output can infer a latch.
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state)
      RUN:     busy = 1'b1;
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh  <= '0;
      b_sh  <= '0;
      carry <= 1'b0;
      count <= '0;
      s     <= '0;
    end else if (accept) begin
      a_sh  <= a;
      b_sh  <= b;
      carry <= 1'b0;
      count <= '0;
      s     <= '0;
    end else if (state == RUN) begin
      s[count] <= sum_bit;
      carry    <= carry_nxt;
      a_sh     <= a_sh >> 1;
      b_sh     <= b_sh >> 1;
      count    <= last ? '0 : count + 1'b1;
      if (last) s[WIDTH] <= carry_nxt;
    end
  end

`ifdef SOMADOR_SERIAL_OVF_EN
  // On the last bit a_sh[0]/b_sh[0] are the operand sign bits and sum_bit is the result sign.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      ovf <= 1'b0;
    else if (accept) ovf <= 1'b0;
    else if (last)   ovf <= (a_sh[0] == b_sh[0]) && (sum_bit != a_sh[0]);
  end
`endif

endmodule

// File: tb/tb_somador_serial.sv
// Self-checking bench for somador_serial: directed corner cases plus random operands against
// an arithmetic reference; define SOMADOR_SERIAL_OVF_EN to also check ovf.
module tb_somador_serial;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a, b;
  logic         busy, done;
  logic [W:0]   s;
`ifdef SOMADOR_SERIAL_OVF_EN
  logic         ovf;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  somador_serial #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .s     (s)
`ifdef SOMADOR_SERIAL_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [W:0] sum_ref(input logic [W-1:0] x, input logic [W-1:0] y);
    return {1'b0, x} + {1'b0, y};
  endfunction

  // Signed overflow: the sign-extended W+1 bit sum does not fit back into W bits.
  function automatic logic ovf_ref(input logic [W-1:0] x, input logic [W-1:0] y);
    int sx, sy, t;
    sx = $signed(x);
    sy = $signed(y);
    t  = sx + sy;
    return (t > (2 ** (W - 1)) - 1) || (t < -(2 ** (W - 1)));
  endfunction

  // Waits (bounded) for done; returns edges elapsed since the accepting edge and busy samples.
  task automatic wait_done(output int cyc, output int busy_cnt);
    cyc      = 0;
    busy_cnt = 0;
    while (!done && cyc < 4 * W) begin
      if (busy) busy_cnt++;
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv, input string tag);
    logic [W:0] exp_s;
    int cyc, busy_cnt;
    exp_s = sum_ref(av, bv);
    @(negedge clk);
    a = av; b = bv; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = W'($urandom);
    b = W'($urandom);
    wait_done(cyc, busy_cnt);
    check({tag, " latency"}, cyc, W);
    check({tag, " busy_cycles"}, busy_cnt, W);
    check({tag, " done"}, done, 1);
    check({tag, " busy_at_done"}, busy, 0);
    check({tag, " s"}, s, exp_s);
`ifdef SOMADOR_SERIAL_OVF_EN
    check({tag, " ovf"}, ovf, ovf_ref(av, bv));
`endif
    @(negedge clk);
    check({tag, " done_pulse"}, done, 0);
    check({tag, " s_hold"}, s, exp_s);
  endtask

  initial begin
    int cyc, busy_cnt, done_seen;
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0;
    #12;
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset s", s, 0);
`ifdef SOMADOR_SERIAL_OVF_EN
    check("reset ovf", ovf, 0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    run_op(8'hFF, 8'h01, "ff_01");
    run_op(8'h00, 8'h00, "zero");
    run_op(8'hFF, 8'hFF, "ff_ff");
    run_op(8'h7F, 8'h01, "7f_01");
    run_op(8'h80, 8'h80, "80_80");

    // Back-to-back with start held high: the DONE cycle accepts the next operation.
    @(negedge clk);
    a = 8'd3; b = 8'd4; start = 1'b1;
    @(negedge clk);
    a = 8'd100; b = 8'd200;
    wait_done(cyc, busy_cnt);
    check("b2b first latency", cyc, W);
    check("b2b first s", s, 9'd7);
    @(negedge clk);
    start = 1'b0;
    check("b2b restart busy", busy, 1);
    check("b2b restart done", done, 0);
    wait_done(cyc, busy_cnt);
    check("b2b second latency", cyc, W);
    check("b2b second s", s, 9'd300);
    @(negedge clk);
    check("b2b idle after", busy, 0);

    // Start pulsed mid-run is ignored and does not corrupt the operation in flight.
    @(negedge clk);
    a = 8'd10; b = 8'd20; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    a = 8'd1; b = 8'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(cyc, busy_cnt);
    check("ignore latency", cyc, W - 3);
    check("ignore s", s, 9'd30);
    @(negedge clk);
    check("ignore no_restart", busy, 0);
    check("ignore s_hold", s, 9'd30);

    // Asynchronous reset mid-run clears outputs at once; nothing resumes afterwards.
    @(negedge clk);
    a = 8'hA5; b = 8'h5A; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    check("rst_mid busy_before", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid busy", busy, 0);
    check("rst_mid done", done, 0);
    check("rst_mid s", s, 0);
    @(negedge clk);
    rst_n = 1'b1;
    done_seen = 0;
    for (int i = 0; i < 2 * W; i++) begin
      @(negedge clk);
      if (done || busy) done_seen++;
    end
    check("rst_mid no_resume", done_seen, 0);

    for (int i = 0; i < 16; i++) begin
      run_op(W'($urandom), W'($urandom), $sformatf("rand%0d", i));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
